// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the mem_arbiter block: FSM state encoding,
// memory read/write encoding and default parameter values.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LINE_WORDS   = 4;
  localparam int DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/mem_arbiter_beat_counter.sv
// Beat index within the current memory transaction, last-beat detection and
// formation of the per-beat memory address.
module mem_arbiter_beat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int BEAT_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              burst_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [BEAT_W-1:0] beat_q, beat_d;

  // Clear wins over increment so a completing last beat leaves the index at 0.
  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (inc_i) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = !burst_i || (beat_q == BEAT_W'(LINE_WORDS - 1));
  assign addr_o = burst_i ? {base_addr_i[ADDR_W-1:BEAT_W+2], beat_q, 2'b00}
                          : base_addr_i;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction line fetches and data accesses onto one memory port.
// Define MEM_ARBITER_STARVE_GUARD_EN to force an instruction grant after STARVE_LIMIT data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LINE_WORDS   = DEF_LINE_WORDS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                          in_Clock,
  input  logic                          in_Reset,
  input  logic                          in_InstructionRequest,
  input  logic [ADDR_W-1:0]             in_InstructionAddress,
  output logic [DATA_W-1:0]             out_InstructionData,
  output logic                          out_InstructionValid,
  output logic                          out_InstructionDone,
  input  logic                          in_DataRequest,
  input  logic [ADDR_W-1:0]             in_DataAddress,
  input  logic                          in_DataRW,
  input  logic                          in_DataBurst,
  input  logic [DATA_W-1:0]             in_DataWriteData,
  output logic [$clog2(LINE_WORDS)-1:0] out_DataBeat,
  output logic [DATA_W-1:0]             out_DataReadData,
  output logic                          out_DataValid,
  output logic                          out_DataDone,
  output logic                          out_MemoryRequest,
  output logic [ADDR_W-1:0]             out_MemoryAddress,
  output logic                          out_MemoryRW,
  output logic [DATA_W-1:0]             out_MemoryWriteData,
  input  logic [DATA_W-1:0]             in_MemoryReadData,
  input  logic                          in_MemoryWait
);

  localparam int BEAT_W = $clog2(LINE_WORDS);

  state_e              state_q, state_d;
  logic                owner_req, beat_done, last_done, is_last, force_inst;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   beat_addr;

  assign owner_req = (state_q == ST_INST) ? in_InstructionRequest :
                     (state_q == ST_DATA) ? in_DataRequest : 1'b0;
  assign beat_done = (state_q != ST_IDLE) && !in_MemoryWait;
  assign last_done = beat_done && owner_req && is_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_DataRequest && !force_inst) begin
          state_d = ST_DATA;
        end else if (in_InstructionRequest) begin
          state_d = ST_INST;
        end
      end
      ST_INST, ST_DATA: begin
        // A withdrawn request or a finished last beat both end the transaction.
        if (!owner_req || last_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                starve_hit;

  assign starve_hit = (starve_q >= STARVE_W'(STARVE_LIMIT));
  assign force_inst = starve_hit && in_InstructionRequest;

  // Counts data grants taken past a waiting fetch; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_IDLE && state_d == ST_INST) begin
      starve_d = '0;
    end else if (state_q == ST_IDLE && state_d == ST_DATA &&
                 in_InstructionRequest && !starve_hit) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge in_Clock) begin
    if (in_Reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_inst = 1'b0;
`endif

  mem_arbiter_beat_counter #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS),
    .BEAT_W     (BEAT_W)
  ) u_beat (
    .clk_i       (in_Clock),
    .rst_i       (in_Reset),
    .clr_i       (state_d == ST_IDLE),
    .inc_i       (beat_done),
    .burst_i     ((state_q == ST_DATA) ? in_DataBurst : 1'b1),
    .base_addr_i ((state_q == ST_DATA) ? in_DataAddress : in_InstructionAddress),
    .beat_o      (beat),
    .last_o      (is_last),
    .addr_o      (beat_addr)
  );

  assign out_InstructionValid = beat_done && !in_Reset && (state_q == ST_INST);
  assign out_InstructionDone  = last_done && !in_Reset && (state_q == ST_INST);
  assign out_DataValid        = beat_done && !in_Reset && (state_q == ST_DATA);
  assign out_DataDone         = last_done && !in_Reset && (state_q == ST_DATA);
  assign out_InstructionData  = in_MemoryReadData;
  assign out_DataReadData     = in_MemoryReadData;
  assign out_DataBeat         = beat;

  assign out_MemoryRequest    = (state_q != ST_IDLE);
  assign out_MemoryAddress    = beat_addr;
  assign out_MemoryRW         = (state_q == ST_DATA) ? in_DataRW : RW_READ;
  assign out_MemoryWriteData  = (state_q == ST_DATA) ? in_DataWriteData : '0;

endmodule
